// File: rtl/reg_file_writeback.sv
// General-purpose register file with HI/LO product capture, ALU status flags
// and a committed-write counter, sitting directly behind the 24-bit ALU.
module reg_file_writeback #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int BYPASS = 0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                RegWrite,
    input  logic [ADDR_W-1:0]   WriteReg,
    input  logic [DATA_W-1:0]   WriteData,
    input  logic [ADDR_W-1:0]   ReadReg1,
    input  logic [ADDR_W-1:0]   ReadReg2,
    output logic [DATA_W-1:0]   ReadData1,
    output logic [DATA_W-1:0]   ReadData2,
    input  logic                MulWrite,
    input  logic [2*DATA_W-1:0] MulOUT,
    output logic [DATA_W-1:0]   HiData,
    output logic [DATA_W-1:0]   LoData,
    input  logic                FlagWrite,
    input  logic                ZeroIn,
    input  logic                OverflowIn,
    input  logic                CoutIn,
    output logic [2:0]          Flags,
    output logic [7:0]          WriteCount
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] gpr_q [NREG];
    logic [DATA_W-1:0] gpr_d [NREG];
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [2:0]        flags_q, flags_d;
    logic [7:0]        write_count_q, write_count_d;
    logic              commit;

    // A GPR write only commits when it targets a non-zero register.
    assign commit = RegWrite && (WriteReg != '0);

    // Next-state for the GPRs; entry 0 is pinned to zero.
    always_comb begin
        gpr_d = gpr_q;
        if (commit) begin
            gpr_d[WriteReg] = WriteData;
        end
        gpr_d[0] = '0;
    end

    // Next-state for HI/LO, flags and the write counter.
    always_comb begin
        hi_d          = hi_q;
        lo_d          = lo_q;
        flags_d       = flags_q;
        write_count_d = write_count_q;
        if (MulWrite) begin
            hi_d = MulOUT[2*DATA_W-1:DATA_W];
            lo_d = MulOUT[DATA_W-1:0];
        end
        if (FlagWrite) begin
            flags_d = {OverflowIn, CoutIn, ZeroIn};
        end
        if (commit) begin
            write_count_d = write_count_q + 8'd1;
        end
    end

    // GPR storage; reset clears every entry immediately.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            gpr_q <= gpr_d;
        end
    end

    // HI/LO, flags and counter state.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hi_q          <= '0;
            lo_q          <= '0;
            flags_q       <= '0;
            write_count_q <= '0;
        end else begin
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            flags_q       <= flags_d;
            write_count_q <= write_count_d;
        end
    end

    // Operand A read, with optional forwarding of the in-flight write.
    always_comb begin
        ReadData1 = gpr_q[ReadReg1];
        if (BYPASS != 0 && commit && WriteReg == ReadReg1) begin
            ReadData1 = WriteData;
        end
        if (ReadReg1 == '0) begin
            ReadData1 = '0;
        end
    end

    // Operand B read, with optional forwarding of the in-flight write.
    always_comb begin
        ReadData2 = gpr_q[ReadReg2];
        if (BYPASS != 0 && commit && WriteReg == ReadReg2) begin
            ReadData2 = WriteData;
        end
        if (ReadReg2 == '0) begin
            ReadData2 = '0;
        end
    end

    assign HiData     = hi_q;
    assign LoData     = lo_q;
    assign Flags      = flags_q;
    assign WriteCount = write_count_q;

endmodule

// File: doc/reg_file_writeback.md
Name: reg_file_writeback

Overview:
- Architectural state block directly downstream of the 24-bit ALU in the single-cycle CPU.
- Holds 16 general-purpose 24-bit registers that feed the ALU A/B operands.
- Captures the ALU Result on writeback, the 48-bit multiply product into HI/LO, and the zero/overflow/COUT flags into a status register.
- Reads are combinational; all state updates occur on the rising Clock edge.

Parameters:
- DATA_W, 24, register and ALU data width
- ADDR_W, 4, register address width (16 registers)
- BYPASS, 0, 1 = read-during-write returns the incoming WriteData; 0 = returns the old value

Ports:
- Clock  input  1  system clock, rising-edge active
- Reset  input  1  asynchronous, active-low; clears all state
- RegWrite  input  1  write enable for the GPR file
- WriteReg  input  ADDR_W  destination register index
- WriteData  input  DATA_W  ALU Result (or memory data, muxed upstream)
- ReadReg1  input  ADDR_W  source register index for ALU operand A
- ReadReg2  input  ADDR_W  source register index for ALU operand B
- ReadData1  output  DATA_W  operand A
- ReadData2  output  DATA_W  operand B
- MulWrite  input  1  capture enable for MulOUT into HI/LO
- MulOUT  input  2*DATA_W  ALU multiply product
- HiData  output  DATA_W  HI register (MulOUT[47:24])
- LoData  output  DATA_W  LO register (MulOUT[23:0])
- FlagWrite  input  1  capture enable for ALU status flags
- ZeroIn  input  1  ALU zero
- OverflowIn  input  1  ALU overflow
- CoutIn  input  1  ALU carry out
- Flags  output  3  registered {Overflow, Cout, Zero}
- WriteCount  output  8  number of committed GPR writes, wraps at 255->0

Behaviour:
- Reset low, applied asynchronously at any time including mid-cycle:
  - all 16 GPRs, HI, LO, Flags and WriteCount go to 0 immediately.
  - While Reset is low, all write enables are ignored.
- Reset release:
  - The first rising edge with Reset high may commit writes.
  - No synchronizer inside; the reset is synchronised upstream.
- GPR write:
  - On a rising edge with RegWrite=1 and WriteReg!=0, reg[WriteReg] <= WriteData.
  - The value is visible on read ports after that edge (latency 1 edge).
- Register 0 is hardwired zero:
  - Writes to index 0 are discarded.
  - Reads of index 0 always return 0, regardless of BYPASS.
  - WriteCount does not increment on a discarded write.
- Reads:
  - ReadData1/2 are purely combinational from ReadReg1/2.
  - Both ports may address the same register.
- Read-during-write (RegWrite=1, WriteReg==ReadRegN, index !=0):
  - BYPASS=0: ReadDataN shows the old content until the edge.
  - BYPASS=1: ReadDataN shows WriteData combinationally.
- HI/LO: on a rising edge with MulWrite=1, HI <= MulOUT[47:24] and LO <= MulOUT[23:0], both in the same edge.
- Flags: on a rising edge with FlagWrite=1, Flags <= {OverflowIn, CoutIn, ZeroIn}; otherwise Flags hold.
- Simultaneous enables: RegWrite, MulWrite and FlagWrite in the same cycle are independent; all take effect on the same edge.
- WriteCount: +1 per committed GPR write (RegWrite=1, WriteReg!=0), 8-bit wrap from 255 to 0, no saturation.
- X/undefined inputs with the relevant enable low must not corrupt state.

Test Plan:
- Reset low for 2 cycles, then high:
  - all 16 registers read 0, HiData=LoData=0, Flags=3'b000, WriteCount=0.
- Write 24'h000004 to R3 and 24'h000003 to R5 on consecutive edges; set ReadReg1=3, ReadReg2=5:
  - ReadData1=4, ReadData2=3.
  - WriteCount=2.
- RegWrite=1, WriteReg=0, WriteData=24'hFFFFFF; read R0:
  - ReadData1=0, WriteCount unchanged.
- MulWrite=1, MulOUT=48'h000001_000002, FlagWrite=1 with Zero=1, Ovf=0, Cout=1:
  - after the edge HiData=24'h000001, LoData=24'h000002, Flags=3'b011.
- Read-during-write to R7 (old 24'h00000A, new 24'h00000C) in the same cycle:
  - BYPASS=0: ReadData1=24'h00000A before the edge and 24'h00000C after.
  - BYPASS=1: ReadData1=24'h00000C before the edge.
- 256 committed writes:
  - WriteCount returns to 0.
  - Pulse Reset low mid-cycle: outputs clear before the next edge.
  - A write asserted during reset is not committed.
